ex_stage_pipe: RTL and testbench
================================

# ex_stage_pipe

Parametrised execute stage for the pipelined LEGv8 datapath, sitting between the register-fetch/decode stage and the memory stage. It computes the ALU result, holds the NZVC flag register, and exposes this cycle's flags combinationally for same-cycle conditional branches. It latches result, store data and control bits into an EX/MEM pipeline register, with valid/ready back-pressure, flush, and an optional iterative multi-cycle multiplier.

## Interface
Parameters:
- DATA_W, 64, operand/result width (≥ 8)
- CTRL_W, 11, width of the pass-through control bundle (MemWrite, MOVZ, MOVK, LDURB, Mem2Reg, RegWrite, read_enable, xfer_size)
- OP_W, 32, width of the passed-through instruction word

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  synchronous kill of output register and any in-flight multiply
- alu_op  in  3  operation select (encoding below)
- set_flags  in  1  instruction writes NZVC
- a, b  in  DATA_W  ALU operands
- db_in  in  DATA_W  store data, passed through
- ctrl_in  in  CTRL_W  control bundle, passed through
- op_in  in  OP_W  instruction word, passed through
- out_valid  out  1  EX/MEM register holds a valid instruction
- out_ready  in  1  downstream accepts this cycle
- result, db_out  out  DATA_W  registered result / store data
- ctrl_out  out  CTRL_W; op_out  out  OP_W  registered pass-through
- flags  out  4  registered {N,Z,V,C}
- flags_fwd  out  4  flags visible to a branch in the same cycle
- busy  out  1  multiplier occupied

## Operation
- alu_op: 000 pass B; 001 reserved (result 0); 010 A+B; 011 A−B (A+~B+1); 100 AND; 101 OR; 110 XOR; 111 MUL (low DATA_W bits of A×B).
- Flags from ALU ops: N = result[DATA_W−1]; Z = (result == 0); add/sub: C = carry-out of bit DATA_W−1 (sub: C = 1 means no borrow), V = signed overflow; all other ops: C = V = 0.
- Accept = in_valid && in_ready && !flush. in_ready = (state == IDLE) && (!out_valid || out_ready).
- Single-cycle op on accept: load result/db/ctrl/op into the output register; out_valid ← 1. If set_flags, flags ← ALU flags.
- MUL never writes flags, even with set_flags = 1.
- flags_fwd = ALU flags when accept && set_flags && alu_op != 111; otherwise the flags register.
- Output register holds while out_valid && !out_ready. out_valid clears when out_ready with no new load.
- FSM:
  - IDLE: accept of MUL latches operands, db/ctrl/op, count ← 0 → MUL_RUN.
  - MUL_RUN: one radix-2 shift-add step per cycle. On count == DATA_W−1: if the slot is free, load the output → IDLE; else → MUL_WAIT.
  - MUL_WAIT: hold product; load when the slot is free → IDLE.
- Flush: out_valid ← 0; FSM → IDLE; flags untouched. Flush wins over a same-cycle accept or load.
- Reset (any state, mid-multiply included): out_valid = 0, result/db_out/ctrl_out/op_out = 0, flags = 0000, state IDLE, busy = 0.

## Timing
- ALU ops: 1 cycle, accept edge → out_valid.
- MUL: DATA_W cycles minimum (accept + DATA_W−1 steps, final load); more if stalled in MUL_WAIT.
- busy = 1 in MUL_RUN and MUL_WAIT; in_ready = 0 throughout.
- Full throughput (one op/cycle) for back-to-back ALU ops with out_ready = 1.
- flags_fwd is combinational from a, b, alu_op and set_flags; no registered delay.

## Configuration
- EX_MULTIPLIER_EN defined: MUL path, MUL_RUN/MUL_WAIT states and counter are present as above.
- Not defined: alu_op 111 is a single-cycle op with result 0 and flags per the "other ops" rule; busy is tied 0; the FSM reduces to IDLE.

## Test plan
- Reset mid-MUL (DATA_W = 64, count = 20): assert reset → next cycle busy = 0, out_valid = 0, flags = 0000, in_ready = 1.
- SUB a = 5, b = 5, set_flags = 1 → same-cycle flags_fwd = 0101 (Z, C); next cycle result = 0, flags = 0101, out_valid = 1.
- ADD a = 0x7FFF_FFFF_FFFF_FFFF, b = 1, set_flags = 1 → result = 0x8000_0000_0000_0000, flags = 1010 (N, V).
- Back-pressure: two ADDs issued with out_ready = 0 → first held in the output register, in_ready = 0; raise out_ready → second accepted next cycle, no loss or duplication.
- MUL a = 12, b = 0xFFFF_FFFF_FFFF_FFFF (macro on) → out_valid exactly 64 cycles after accept, result = 0xFFFF_FFFF_FFFF_FFF4, flags unchanged.
- Flush on cycle 10 of a MUL → busy = 0 and out_valid = 0 next cycle; the next ADD 2+3 yields result = 5 in 1 cycle.

Source files
------------

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: LEGv8 execute stage with NZVC flag register, EX/MEM output
// register under valid/ready handshake, synchronous flush, and an optional
// radix-2 iterative multiplier enabled by defining EX_MULTIPLIER_EN.
// Without EX_MULTIPLIER_EN, alu_op 111 is a plain single-cycle op giving 0.
module ex_stage_pipe #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 11,
  parameter int OP_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [2:0]        alu_op,
  input  logic              set_flags,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] db_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [OP_W-1:0]   op_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] db_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [OP_W-1:0]   op_out,
  output logic [3:0]        flags,
  output logic [3:0]        flags_fwd,
  output logic              busy
);

  localparam int MSB = DATA_W - 1;

  localparam logic [2:0] OP_PASSB = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  logic [DATA_W:0]   add_ext;
  logic [DATA_W:0]   sub_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic [3:0]        alu_flags;

  logic              slot_free;
  logic              accept;
  logic              is_mul;
  logic              flag_wr;
  logic              alu_load;
  logic              mul_load;
  logic              load_out;
  logic [DATA_W-1:0] load_res;
  logic [DATA_W-1:0] load_db;
  logic [CTRL_W-1:0] load_ctrl;
  logic [OP_W-1:0]   load_op;

  // Subtraction is A + ~B + 1 so the carry-out reads as "no borrow".
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

  // Single-cycle ALU result and carry/overflow; MUL and reserved yield zero here.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      OP_PASSB: alu_res = b;
      OP_ADD: begin
        alu_res = add_ext[DATA_W-1:0];
        alu_c   = add_ext[DATA_W];
        alu_v   = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_ext[DATA_W-1:0];
        alu_c   = sub_ext[DATA_W];
        alu_v   = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = {alu_res[MSB], (alu_res == '0), alu_v, alu_c};

  // The output slot can take a new entry when empty or draining this cycle.
  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign alu_load  = accept && !is_mul;
  assign load_out  = alu_load || mul_load;
  assign flag_wr   = accept && set_flags && !is_mul;
  assign flags_fwd = flag_wr ? alu_flags : flags;

`ifdef EX_MULTIPLIER_EN

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    MUL_WAIT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mul_db;
  logic [CTRL_W-1:0] mul_ctrl;
  logic [OP_W-1:0]   mul_op;
  logic [DATA_W-1:0] mul_step;
  logic              mul_last;

  assign is_mul   = (alu_op == OP_MUL);
  assign mul_step = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (count == CNT_W'(DATA_W - 1));
  assign mul_load = (((state == MUL_RUN) && mul_last) || (state == MUL_WAIT)) && slot_free;
  assign in_ready = (state == IDLE) && slot_free;
  assign busy     = (state != IDLE);

  // The final step's sum goes straight to the output; after a stall it sits in acc.
  always_comb begin
    load_res  = alu_res;
    load_db   = db_in;
    load_ctrl = ctrl_in;
    load_op   = op_in;
    if (mul_load) begin
      load_res  = (state == MUL_RUN) ? mul_step : acc;
      load_db   = mul_db;
      load_ctrl = mul_ctrl;
      load_op   = mul_op;
    end
  end

  // Multiplier sequencer: latch operands, one shift-add step per cycle, then hand off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      mul_db   <= '0;
      mul_ctrl <= '0;
      mul_op   <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_mul) begin
            mcand    <= a;
            mplier   <= b;
            acc      <= '0;
            count    <= '0;
            mul_db   <= db_in;
            mul_ctrl <= ctrl_in;
            mul_op   <= op_in;
            state    <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          acc    <= mul_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (mul_last) begin
            state <= slot_free ? IDLE : MUL_WAIT;
          end
        end
        MUL_WAIT: begin
          if (slot_free) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  assign is_mul    = 1'b0;
  assign mul_load  = 1'b0;
  assign in_ready  = slot_free;
  assign busy      = 1'b0;
  assign load_res  = alu_res;
  assign load_db   = db_in;
  assign load_ctrl = ctrl_in;
  assign load_op   = op_in;

`endif

  // EX/MEM register: flush kills it, a load fills it, a downstream take empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      db_out    <= '0;
      ctrl_out  <= '0;
      op_out    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      result    <= load_res;
      db_out    <= load_db;
      ctrl_out  <= load_ctrl;
      op_out    <= load_op;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // NZVC register, written only by accepted non-multiply instructions that ask for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (flag_wr) begin
      flags <= alu_flags;
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed and randomized checks of ex_stage_pipe against a
// transaction-level model (output slot, pending multiply, flag register).
// Define EX_MULTIPLIER_EN for both bench and RTL to cover the multiplier.
module tb_ex_stage_pipe;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 11;
  localparam int OP_W   = 32;

`ifdef EX_MULTIPLIER_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic [2:0]        alu_op = 3'b000;
  logic              set_flags = 1'b0;
  logic [DATA_W-1:0] a = '0;
  logic [DATA_W-1:0] b = '0;
  logic [DATA_W-1:0] db_in = '0;
  logic [CTRL_W-1:0] ctrl_in = '0;
  logic [OP_W-1:0]   op_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] db_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [OP_W-1:0]   op_out;
  logic [3:0]        flags;
  logic [3:0]        flags_fwd;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  ex_stage_pipe #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .OP_W(OP_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .alu_op(alu_op), .set_flags(set_flags), .a(a), .b(b),
    .db_in(db_in), .ctrl_in(ctrl_in), .op_in(op_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .db_out(db_out),
    .ctrl_out(ctrl_out), .op_out(op_out), .flags(flags),
    .flags_fwd(flags_fwd), .busy(busy)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, reports a miss with both values.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic sf,
                               input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv,
                               input logic [DATA_W-1:0] dv, input logic [CTRL_W-1:0] cv,
                               input logic [OP_W-1:0] ov, input logic ordy, input logic fl);
    in_valid  = v;
    alu_op    = op;
    set_flags = sf;
    a         = av;
    b         = bv;
    db_in     = dv;
    ctrl_in   = cv;
    op_in     = ov;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 3'b000, 1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from plain arithmetic; overflow via exact signed sums.
  function automatic void ref_alu(input logic [2:0] op, input logic [DATA_W-1:0] x,
                                  input logic [DATA_W-1:0] y,
                                  output logic [DATA_W-1:0] res, output logic [3:0] fl);
    logic c, v;
    logic [DATA_W:0] wide;
    logic signed [DATA_W+1:0] sx, sy, ss, sr;
    c = 1'b0;
    v = 1'b0;
    res = '0;
    sx = {{2{x[DATA_W-1]}}, x};
    sy = {{2{y[DATA_W-1]}}, y};
    case (op)
      3'd0: res = y;
      3'd2: begin
        res = x + y;
        wide = {1'b0, x} + {1'b0, y};
        c = wide[DATA_W];
        ss = sx + sy;
        sr = {{2{res[DATA_W-1]}}, res};
        v = (ss != sr);
      end
      3'd3: begin
        res = x - y;
        c = (x >= y);
        ss = sx - sy;
        sr = {{2{res[DATA_W-1]}}, res};
        v = (ss != sr);
      end
      3'd4: res = x & y;
      3'd5: res = x | y;
      3'd6: res = x ^ y;
      3'd7: res = MUL_EN ? x * y : '0;
      default: res = '0;
    endcase
    fl = {res[DATA_W-1], (res == '0), v, c};
  endfunction

  // Model state: what the output slot holds, a pending multiply, the flag register.
  bit                m_occ = 1'b0;
  bit                m_mul = 1'b0;
  int                m_steps = 0;
  logic [DATA_W-1:0] m_res = '0, m_db = '0, p_res = '0, p_db = '0;
  logic [CTRL_W-1:0] m_ctrl = '0, p_ctrl = '0;
  logic [OP_W-1:0]   m_op = '0, p_op = '0;
  logic [3:0]        m_flags = 4'b0000;

  // Compare every cycle at the falling edge, then advance the model on the rising edge.
  initial begin
    logic              ir, acc, ld;
    logic [DATA_W-1:0] r;
    logic [3:0]        f, ffwd;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_occ = 1'b0;
        m_mul = 1'b0;
        m_steps = 0;
        m_flags = 4'b0000;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_flags", flags, 0);
        checkOutput("rst_result", result, 0);
      end else begin
        ir  = !m_mul && (!m_occ || out_ready);
        acc = in_valid && ir && !flush;
        ref_alu(alu_op, a, b, r, f);
        ffwd = (acc && set_flags && !(MUL_EN && alu_op == 3'd7)) ? f : m_flags;
        checkOutput("mdl_in_ready", in_ready, ir);
        checkOutput("mdl_busy", busy, m_mul);
        checkOutput("mdl_out_valid", out_valid, m_occ);
        checkOutput("mdl_flags", flags, m_flags);
        checkOutput("mdl_flags_fwd", flags_fwd, ffwd);
        if (m_occ) begin
          checkOutput("mdl_result", result, m_res);
          checkOutput("mdl_db_out", db_out, m_db);
          checkOutput("mdl_ctrl_out", ctrl_out, m_ctrl);
          checkOutput("mdl_op_out", op_out, m_op);
        end
      end
      @(posedge clk);
      if (!reset) begin
        ir  = !m_mul && (!m_occ || out_ready);
        acc = in_valid && ir && !flush;
        ref_alu(alu_op, a, b, r, f);
        if (flush) begin
          m_occ = 1'b0;
          m_mul = 1'b0;
        end else begin
          ld = 1'b0;
          if (m_mul) begin
            if (m_steps > 1) begin
              m_steps--;
            end else if (!m_occ || out_ready) begin
              ld = 1'b1;
              m_res = p_res; m_db = p_db; m_ctrl = p_ctrl; m_op = p_op;
              m_mul = 1'b0;
            end
          end else if (acc) begin
            if (MUL_EN && alu_op == 3'd7) begin
              m_mul = 1'b1;
              m_steps = DATA_W;
              p_res = r; p_db = db_in; p_ctrl = ctrl_in; p_op = op_in;
            end else begin
              ld = 1'b1;
              m_res = r; m_db = db_in; m_ctrl = ctrl_in; m_op = op_in;
              if (set_flags) m_flags = f;
            end
          end
          if (ld) m_occ = 1'b1;
          else if (out_ready) m_occ = 1'b0;
        end
      end
    end
  end

  // Directed scenarios with literal expectations, then a randomized soak.
  initial begin
    int n;
    logic [DATA_W-1:0] ra, rb;
    logic [2:0] rop;

    idleInputs();
    reset = 1'b1;
    step();
    step();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_flags", flags, 4'b0000);
    checkOutput("reset_in_ready", in_ready, 1);
    reset = 1'b0;
    step();

    // SUB 5-5 with flags: Z and C, forwarded in the same cycle.
    applyStimulus(1'b1, 3'b011, 1'b1, 64'd5, 64'd5, 64'h00AA, 11'h155, 32'hCB000000, 1'b1, 1'b0);
    #1;
    checkOutput("sub_flags_fwd", flags_fwd, 4'b0101);
    step();
    idleInputs();
    checkOutput("sub_result", result, 0);
    checkOutput("sub_flags", flags, 4'b0101);
    checkOutput("sub_out_valid", out_valid, 1);
    checkOutput("sub_db_out", db_out, 64'h00AA);

    // Signed overflow on ADD: N and V.
    applyStimulus(1'b1, 3'b010, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, '0, '0, '0, 1'b1, 1'b0);
    step();
    idleInputs();
    checkOutput("addov_result", result, 64'h8000_0000_0000_0000);
    checkOutput("addov_flags", flags, 4'b1010);

    // Back-pressure: second ADD waits until the first drains.
    step();
    applyStimulus(1'b1, 3'b010, 1'b0, 64'd10, 64'd20, '0, 11'h001, 32'h1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 3'b010, 1'b0, 64'd100, 64'd200, '0, 11'h002, 32'h2, 1'b0, 1'b0);
    #1;
    checkOutput("bp_first_result", result, 64'd30);
    checkOutput("bp_in_ready_low", in_ready, 0);
    step();
    step();
    checkOutput("bp_held_result", result, 64'd30);
    checkOutput("bp_held_op", op_out, 32'h1);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_high", in_ready, 1);
    step();
    idleInputs();
    checkOutput("bp_second_result", result, 64'd300);
    checkOutput("bp_second_op", op_out, 32'h2);
    step();
    checkOutput("bp_drained", out_valid, 0);

`ifdef EX_MULTIPLIER_EN
    // MUL latency and product; flags stay at the ADD-overflow value.
    applyStimulus(1'b1, 3'b111, 1'b1, 64'd12, 64'hFFFF_FFFF_FFFF_FFFF, '0, '0, 32'h77, 1'b1, 1'b0);
    #1;
    checkOutput("mul_flags_fwd", flags_fwd, 4'b1010);
    step();
    idleInputs();
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    checkOutput("mul_latency", n, 64);
    checkOutput("mul_result", result, 64'hFFFF_FFFF_FFFF_FFF4);
    checkOutput("mul_flags", flags, 4'b1010);
    checkOutput("mul_busy_done", busy, 0);
    step();

    // Flush in the middle of a multiply, then a quick ADD.
    applyStimulus(1'b1, 3'b111, 1'b0, 64'd3, 64'd7, '0, '0, '0, 1'b1, 1'b0);
    step();
    idleInputs();
    repeat (9) step();
    checkOutput("flush_busy_before", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_busy_after", busy, 0);
    checkOutput("flush_out_valid", out_valid, 0);
    applyStimulus(1'b1, 3'b010, 1'b0, 64'd2, 64'd3, '0, '0, '0, 1'b1, 1'b0);
    step();
    idleInputs();
    checkOutput("flush_add_result", result, 64'd5);
    checkOutput("flush_add_valid", out_valid, 1);
    step();

    // Reset while the multiplier is mid-run.
    applyStimulus(1'b1, 3'b111, 1'b0, 64'd9, 64'd9, '0, '0, '0, 1'b1, 1'b0);
    step();
    idleInputs();
    repeat (20) step();
    reset = 1'b1;
    step();
    checkOutput("rstmul_busy", busy, 0);
    checkOutput("rstmul_out_valid", out_valid, 0);
    checkOutput("rstmul_flags", flags, 4'b0000);
    checkOutput("rstmul_in_ready", in_ready, 1);
    reset = 1'b0;
    step();
`else
    // Without the multiplier, 111 is single-cycle: result 0, Z set.
    applyStimulus(1'b1, 3'b111, 1'b1, 64'd12, 64'd34, '0, '0, '0, 1'b1, 1'b0);
    #1;
    checkOutput("op7_flags_fwd", flags_fwd, 4'b0100);
    step();
    idleInputs();
    checkOutput("op7_result", result, 0);
    checkOutput("op7_flags", flags, 4'b0100);
    checkOutput("op7_busy", busy, 0);
    step();
`endif

    // Randomized soak; the model process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 64'h7FFF_FFFF_FFFF_FFFF;
        1: ra = 64'h8000_0000_0000_0000;
        2: ra = 64'(($urandom_range(0, 15)));
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 4))
        0: rb = 64'hFFFF_FFFF_FFFF_FFFF;
        1: rb = ra;
        2: rb = 64'(($urandom_range(0, 15)));
        default: rb = {$urandom, $urandom};
      endcase
      rop = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      applyStimulus(($urandom_range(0, 9) < 7), rop, 1'($urandom_range(0, 1)), ra, rb,
                    {$urandom, $urandom}, 11'($urandom), 32'($urandom),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
      step();
    end

    idleInputs();
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
